// File: rtl/mux_tt_sweep_ctrl.sv
// mux_tt_sweep_ctrl: steps the 8-to-1 mux through all 16 input vectors and captures its truth table
module mux_tt_sweep_ctrl #(
  parameter int SETTLE = 2,
  parameter int CW     = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic        iY,
  output logic        oA,
  output logic        oB,
  output logic        oC,
  output logic        oD,
  output logic [15:0] oTable,
  output logic        oBusy,
  output logic        oDone
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  state_t        r_state, w_next;
  logic [3:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_table;
  logic          r_busy, r_done;
  assign {oA, oB, oC, oD} = r_idx;
  assign oTable = r_table;
  assign oBusy  = r_busy;
  assign oDone  = r_done;
  // state register
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  // next state; abort overrides both the settle and sample exits
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = iStart ? S_SETTLE : S_IDLE;
      S_SETTLE: w_next = iAbort ? S_IDLE : (r_cnt == LAST) ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: w_next = iAbort ? S_IDLE : (r_idx == 4'd15) ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // vector index, settle counter and captured table; abort drops the pending sample
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_table <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (iStart) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_table <= '0;
          end
        S_SETTLE:
          if (iAbort) begin
            r_idx <= '0;
            r_cnt <= '0;
          end else r_cnt <= r_cnt + CW'(1);
        S_SAMPLE:
          if (iAbort) begin
            r_idx <= '0;
            r_cnt <= '0;
          end else begin
            r_table[r_idx] <= iY;
            r_cnt          <= '0;
            if (r_idx != 4'd15) r_idx <= r_idx + 4'd1;
          end
        S_DONE:   r_idx <= '0;
        default:  r_idx <= '0;
      endcase
    end
  // status flags registered from the next state so they track the state register exactly
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == S_SETTLE) || (w_next == S_SAMPLE);
      r_done <= (w_next == S_DONE);
    end
endmodule

// File: tb/tb_mux_tt_sweep_ctrl.sv
// tb_mux_tt_sweep_ctrl: table-driven sweeps plus abort, held-start and async-reset sequences
module tb_mux_tt_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, abort, y;
  logic a, b, c, d, busy, done;
  logic [15:0] table_q;
  int mode;
  int total = 0;
  int bad = 0;
  logic [15:0] sb[$];

  typedef struct {
    int          mode;
    logic [15:0] exp;
    bit          tog;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  mux_tt_sweep_ctrl #(.SETTLE(2), .CW(4)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iAbort(abort), .iY(y),
    .oA(a), .oB(b), .oC(c), .oD(d), .oTable(table_q), .oBusy(busy), .oDone(done)
  );

  // environment model of the mux output for each wiring mode
  always_comb
    y = (mode == 0) ? d :
        (mode == 1) ? a :
        (mode == 2) ? (a ^ b ^ c ^ d) :
        (mode == 3) ? 1'b0 :
        (mode == 4) ? 1'b1 :
        (mode == 5) ? c : b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty act=%h", nm, table_q);
    end else chk(nm, table_q, sb.pop_front());
  endtask

  task automatic sweep(input int m, input logic [15:0] exp, input bit tog);
    int n, busy_n;
    bit seq_ok;
    mode = m;
    @(negedge clk); start = 1'b1; sb.push_back(exp);
    @(negedge clk); start = 1'b0;
    chk("start_clear", table_q, 0);
    n = 0; busy_n = 0; seq_ok = 1'b1;
    while (!done && n < 200) begin
      if (busy) busy_n++;
      if ({a, b, c, d} !== 4'(n / 3)) seq_ok = 1'b0;
      start = tog && (n % 4 == 1);
      @(negedge clk); n++;
    end
    start = 1'b0;
    chk("latency", n, 48);
    chk("busy_cycles", busy_n, 48);
    chk("vec_seq", {31'd0, seq_ok}, 1);
    sb_check("table");
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("no_restart", {31'd0, busy}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    tbl[0] = '{0, 16'hAAAA, 1'b0};
    tbl[1] = '{1, 16'hFF00, 1'b0};
    tbl[2] = '{2, 16'h6996, 1'b0};
    tbl[3] = '{2, 16'h6996, 1'b0};
    tbl[4] = '{3, 16'h0000, 1'b1};
    tbl[5] = '{4, 16'hFFFF, 1'b0};
    tbl[6] = '{5, 16'hCCCC, 1'b1};
    tbl[7] = '{6, 16'hF0F0, 1'b0};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {table_q, 12'd0, a, b, c, d, 2'd0, busy, done}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {table_q, 12'd0, a, b, c, d, 2'd0, busy, done}, 0);

    for (int i = 0; i < 8; i++) sweep(tbl[i].mode, tbl[i].exp, tbl[i].tog);

    // abort during the sample cycle of vector 5
    mode = 4;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_vec", {28'd0, a, b, c, d}, 5);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_table", table_q, 16'h001F);
    chk("abort_vec0", {28'd0, a, b, c, d}, 0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      seen |= done | busy;
      @(negedge clk);
    end
    chk("abort_quiet", {31'd0, seen}, 0);

    // start held high: back-to-back sweeps with DONE plus one IDLE cycle between
    mode = 1;
    @(negedge clk); start = 1'b1; sb.push_back(16'hFF00);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk); n++;
    end
    chk("held_latency", n, 49);
    sb_check("held_table1");
    @(negedge clk);
    chk("held_gap", {30'd0, busy, done}, 0);
    @(negedge clk);
    chk("held_restart", {31'd0, busy}, 1);
    chk("held_clear", table_q, 0);
    sb.push_back(16'hFF00);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk); n++;
    end
    start = 1'b0;
    chk("held_latency2", n, 48);
    sb_check("held_table2");
    repeat (2) @(negedge clk);
    chk("held_stop", {31'd0, busy}, 0);

    // asynchronous reset during vector 9
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (28) @(negedge clk);
    chk("rst_vec", {28'd0, a, b, c, d}, 9);
    chk("rst_partial", table_q, 16'h00AA);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {table_q, 12'd0, a, b, c, d, 2'd0, busy, done}, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen |= busy | done | a | b | c | d;
    end
    chk("rst_idle", {31'd0, seen}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_tt_sweep_ctrl.md
Name: mux_tt_sweep_ctrl

Overview:
- Sequencer that drives the four inputs of the 8-to-1 mux function block (iA,iB,iC as select, iD as data) through all 16 combinations.
- Samples the mux output oY after a programmable settle time and assembles a 16-bit captured truth table.
- Sits between the mux block and the board-level / self-test logic; replaces the hand-written exhaustive stimulus with on-chip sequencing.
- Start/done handshake; abortable.

Parameters:
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.
- CW, 4, width of settle counter; must satisfy 2^CW > SETTLE.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iStart  input  1  start request; accepted only in IDLE.
- iAbort  input  1  abort current sweep; synchronous, highest priority after reset.
- iY  input  1  mux output under sequence (connect to mux oY).
- oA  output  1  vector bit 3 (MSB), to mux iA.
- oB  output  1  vector bit 2, to mux iB.
- oC  output  1  vector bit 1, to mux iC.
- oD  output  1  vector bit 0 (LSB), to mux iD.
- oTable  output  16  captured truth table; bit k = iY sampled while {oA,oB,oC,oD}=k.
- oBusy  output  1  high while sweep is in progress (SETTLE or SAMPLE state).
- oDone  output  1  one-cycle completion pulse.

Behaviour:
- Reset (iRst_n=0, async): state=IDLE; idx=0; cnt=0; oTable=0; oA..oD=0; oBusy=0; oDone=0.
- Vector outputs: {oA,oB,oC,oD} = idx register, so they are glitch-free registered outputs.
- States:
  - IDLE: oBusy=0. When iStart=1: idx=0, cnt=0, oTable=0, go to SETTLE.
  - SETTLE: cnt increments each cycle. When cnt==SETTLE-1, go to SAMPLE.
  - SAMPLE: oTable[idx]<=iY.
    - If idx==15: go to DONE.
    - Otherwise: idx<=idx+1, cnt<=0, go to SETTLE.
  - DONE: oDone=1 for exactly this one cycle; idx<=0; go to IDLE.
- oBusy is registered and equals (state==SETTLE or state==SAMPLE).
- oDone is registered and equals (state==DONE).
- Timing:
  - Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 in SAMPLE.
  - With start accepted at edge 0, state is DONE after edge 16*(SETTLE+1).
  - oBusy is high for exactly 16*(SETTLE+1) cycles.
- iStart:
  - Level-sensitive, sampled only in IDLE.
  - Ignored in SETTLE, SAMPLE and DONE; no queuing.
  - If iStart is held high, a new sweep starts on the cycle after DONE, i.e. one IDLE cycle later.
- iAbort:
  - In SETTLE or SAMPLE: next state IDLE, idx=0, cnt=0, no oDone pulse.
  - oTable keeps the bits captured so far. The sample scheduled on the abort cycle is NOT written.
  - iAbort wins over a simultaneous SAMPLE or idx==15 transition.
  - In IDLE or DONE, iAbort has no effect; a DONE pulse is still emitted.
- Simultaneous iStart and iAbort in IDLE: start is accepted.
- idx wrap: idx never wraps 15->0 by increment; it is cleared only in DONE, on abort, or on reset.
- oTable is stable and valid from the DONE cycle until the next accepted start, which clears it.
- Async reset mid-sweep clears everything immediately, including oTable; no oDone pulse.

Test Plan:
- Reset, then iStart pulse with iY tied to oD (data passthrough, select irrelevant), SETTLE=2 -> oDone pulses 48 cycles after the start edge; oTable=16'hAAAA; oBusy high exactly 48 cycles.
- iY tied to oA -> oTable=16'hFF00; vectors observed on oA..oD step 0,1,...,15 in order, each held 3 cycles.
- iY = oA^oB^oC^oD (real mux_8na1 configured for parity) -> oTable=16'h6996; a second iStart after completion clears oTable and yields 16'h6996 again.
- iAbort asserted in SAMPLE of vector 5 with iY=1 -> state IDLE next cycle; oBusy=0; no oDone; oTable=16'h001F (bit 5 not written); oA..oD=0.
- iStart toggled during sweep, and iStart held high continuously -> mid-sweep pulses ignored; with iStart held, back-to-back sweeps separated by DONE plus one IDLE cycle.
- iRst_n pulled low mid-sweep (vector 9) -> all outputs 0 immediately (asynchronous, before next clock edge); after release, IDLE until next iStart.
